vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/vga_timing_gen_if.sv | 40 ++++
 rtl/vga_axis_counter.sv | 77 +++++++
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA timing generator.
//   vga_mode_t        : one complete timing mode (H/V widths and sync polarity)
//   MODE_640x480_60   : 640x480 @ 60 Hz, 25 MHz pixel clock, negative syncs
//   MODE_800x600_60   : 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
//   axis_total()      : period of one axis (visible + porches + sync)
//   mode_h_total()    : pixels per line of a mode
//   mode_v_total()    : lines per frame of a mode
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  typedef struct packed {
    int   h_visible;
    int   h_front;
    int   h_sync;
    int   h_back;
    int   v_visible;
    int   v_front;
    int   v_sync;
    int   v_back;
    logic hs_pol;
    logic vs_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640x480_60 = '{
    h_visible: 640, h_front: 16, h_sync: 96,  h_back: 48,
    v_visible: 480, v_front: 10, v_sync: 2,   v_back: 33,
    hs_pol: 1'b0,   vs_pol: 1'b0
  };

  localparam vga_mode_t MODE_800x600_60 = '{
    h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_visible: 600, v_front: 1,  v_sync: 4,   v_back: 23,
    hs_pol: 1'b1,   vs_pol: 1'b1
  };

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  function automatic int mode_h_total(input vga_mode_t m);
    return axis_total(m.h_visible, m.h_front, m.h_sync, m.h_back);
  endfunction

  function automatic int mode_v_total(input vga_mode_t m);
    return axis_total(m.v_visible, m.v_front, m.v_sync, m.v_back);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle between the timing generator and the pixel pipeline.
//   enable       : pipeline lets the raster advance (freeze when low)
//   x, y         : current pixel column / line
//   hsync, vsync : registered sync levels
//   activevideo  : registered, inside visible area
//   vblank       : registered, inside vertical blanking
//   pix_tick     : last system clock of the current pixel
//   line_start   : one-clock strobe, first clock of x==0
//   frame_start  : one-clock strobe, first clock of (0,0)
// Modports: master = timing generator, slave = pixel pipeline.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int XBITS = 10,
  parameter int YBITS = 10
);
  logic             enable;
  logic [XBITS-1:0] x;
  logic [YBITS-1:0] y;
  logic             hsync;
  logic             vsync;
  logic             activevideo;
  logic             vblank;
  logic             pix_tick;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  enable,
    output x, y, hsync, vsync, activevideo, vblank,
           pix_tick, line_start, frame_start
  );

  modport slave (
    output enable,
    input  x, y, hsync, vsync, activevideo, vblank,
           pix_tick, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a wrapping position counter with its sync decode.
//   clk, rst_n : system clock, asynchronous active-low reset
//   advance    : step the position on this edge
//   count      : current position, 0..TOTAL-1 (registered)
//   wrap       : this edge takes the position from TOTAL-1 back to 0
//   sync       : sync level for the current position (registered)
//   active     : visible flag of the position being loaded on this edge;
//                the caller registers it together with its other flags
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   VISIBLE = 640,
  parameter int   FRONT   = 16,
  parameter int   SYNC    = 96,
  parameter int   BACK    = 48,
  parameter logic POL     = 1'b0,
  parameter int   WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] VIS_END    = WIDTH'(VISIBLE);
  localparam logic [WIDTH-1:0] SYNC_FIRST = WIDTH'(VISIBLE + FRONT);
  localparam logic [WIDTH-1:0] SYNC_LAST  = WIDTH'(VISIBLE + FRONT + SYNC - 1);

  if (VISIBLE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_width
    $error("vga_axis_counter: every visible/porch/sync width must be >= 1");
  end
  if (longint'(TOTAL) > (longint'(1) << WIDTH)) begin : g_bad_total
    $error("vga_axis_counter: axis total does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             sync_reg;
  logic             sync_next;

  always_comb begin
    count_next = count_reg;
    if (advance) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  // Decoding the next position lets sync change on the very edge that
  // moves the counter, so position and sync never skew.
  assign sync_next = ((count_next >= SYNC_FIRST) && (count_next <= SYNC_LAST))
                     ? POL : ~POL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      sync_reg  <= ~POL;
    end else begin
      count_reg <= count_next;
      sync_reg  <= sync_next;
    end
  end

  assign count  = count_reg;
  assign sync   = sync_reg;
  assign wrap   = advance && (count_reg == LAST);
  assign active = (count_next < VIS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   vif   : vga_timing_gen_if.master
//           in : enable
//           out: x, y, hsync, vsync, activevideo, vblank,
//                pix_tick, line_start, frame_start
// A prescaler divides clk by CLK_DIV to form the pixel rate; x advances on
// pix_tick, y advances when x wraps. All raster outputs except pix_tick are
// registered and change on the same edge as x/y.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = MODE_640x480_60.h_visible,
  parameter int   H_FRONT   = MODE_640x480_60.h_front,
  parameter int   H_SYNC    = MODE_640x480_60.h_sync,
  parameter int   H_BACK    = MODE_640x480_60.h_back,
  parameter int   V_VISIBLE = MODE_640x480_60.v_visible,
  parameter int   V_FRONT   = MODE_640x480_60.v_front,
  parameter int   V_SYNC    = MODE_640x480_60.v_sync,
  parameter int   V_BACK    = MODE_640x480_60.v_back,
  parameter int   CLK_DIV   = 4,
  parameter logic HS_POL    = MODE_640x480_60.hs_pol,
  parameter logic VS_POL    = MODE_640x480_60.vs_pol,
  parameter int   XBITS     = 10,
  parameter int   YBITS     = 10
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master vif
);

  localparam vga_mode_t MODE = '{
    h_visible: H_VISIBLE, h_front: H_FRONT, h_sync: H_SYNC, h_back: H_BACK,
    v_visible: V_VISIBLE, v_front: V_FRONT, v_sync: V_SYNC, v_back: V_BACK,
    hs_pol: HS_POL, vs_pol: VS_POL
  };
  localparam int H_TOTAL = mode_h_total(MODE);
  localparam int V_TOTAL = mode_v_total(MODE);

  // A divide-by-one prescaler still needs a one-bit register to exist.
  localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (longint'(H_TOTAL) > (longint'(1) << XBITS)) begin : g_bad_xbits
    $error("vga_timing_gen: H_TOTAL does not fit in XBITS");
  end
  if (longint'(V_TOTAL) > (longint'(1) << YBITS)) begin : g_bad_ybits
    $error("vga_timing_gen: V_TOTAL does not fit in YBITS");
  end

  logic [PW-1:0]    prescaler_reg;
  logic [PW-1:0]    prescaler_next;
  logic             pix_tick;

  logic [XBITS-1:0] x_count;
  logic             x_wrap;
  logic             x_sync;
  logic             x_active;
  logic [YBITS-1:0] y_count;
  logic             y_wrap;
  logic             y_sync;
  logic             y_active;

  logic             activevideo_reg;
  logic             vblank_reg;
  logic             line_start_reg;
  logic             frame_start_reg;

  assign pix_tick = vif.enable && (prescaler_reg == PRE_LAST);

  // With enable low the prescaler holds, so a stalled pixel resumes
  // exactly where it stopped.
  always_comb begin
    prescaler_next = prescaler_reg;
    if (pix_tick) begin
      prescaler_next = '0;
    end else if (vif.enable) begin
      prescaler_next = prescaler_reg + 1'b1;
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HS_POL),
    .WIDTH   (XBITS)
  ) u_x_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (pix_tick),
    .count   (x_count),
    .wrap    (x_wrap),
    .sync    (x_sync),
    .active  (x_active)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VS_POL),
    .WIDTH   (YBITS)
  ) u_y_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (x_wrap),
    .count   (y_count),
    .wrap    (y_wrap),
    .sync    (y_sync),
    .active  (y_active)
  );

  // The combined flags are registered here rather than ANDed after the
  // axis flops: at a line wrap both axis flags flip together and a
  // combinational AND could glitch on the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg   <= '0;
      activevideo_reg <= 1'b1;
      vblank_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      prescaler_reg   <= prescaler_next;
      activevideo_reg <= x_active && y_active;
      vblank_reg      <= !y_active;
      line_start_reg  <= x_wrap;
      // y can only wrap on an x wrap, so this marks the (0,0) edge.
      frame_start_reg <= x_wrap && y_wrap;
    end
  end

  assign vif.x           = x_count;
  assign vif.y           = y_count;
  assign vif.hsync       = x_sync;
  assign vif.vsync       = y_sync;
  assign vif.activevideo = activevideo_reg;
  assign vif.vblank      = vblank_reg;
  assign vif.pix_tick    = pix_tick;
  assign vif.line_start  = line_start_reg;
  assign vif.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Four configurations: 0 small mode /3, 1 small mode /1 positive syncs,
  // 2 default 640x480 /4, 3 the 800x600 preset /1.
  localparam int T_HV  [4] = '{16, 16, 640, 800};
  localparam int T_HF  [4] = '{3,  2,  16,  40};
  localparam int T_HS  [4] = '{4,  3,  96,  128};
  localparam int T_HB  [4] = '{5,  2,  48,  88};
  localparam int T_VV  [4] = '{8,  6,  480, 600};
  localparam int T_VF  [4] = '{2,  1,  10,  1};
  localparam int T_VS  [4] = '{2,  2,  2,   4};
  localparam int T_VB  [4] = '{3,  1,  33,  23};
  localparam int T_DIV [4] = '{3,  1,  4,   1};
  localparam bit T_HP  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit T_VP  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_n_v = 4'hF;
  logic [3:0]  en_v    = 4'h0;
  logic [38:0] got_v [4];
  bit          chk_on  = 1'b0;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  vga_timing_gen_if #(.XBITS(5), .YBITS(4)) if_a ();
  vga_timing_gen_if #(.XBITS(5), .YBITS(4)) if_b ();
  vga_timing_gen_if #(.XBITS(10), .YBITS(10)) if_c ();
  vga_timing_gen_if #(.XBITS(11), .YBITS(10)) if_d ();
  assign if_a.enable = en_v[0];
  assign if_b.enable = en_v[1];
  assign if_c.enable = en_v[2];
  assign if_d.enable = en_v[3];

  vga_timing_gen #(.H_VISIBLE(16), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
                   .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                   .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b0), .XBITS(5), .YBITS(4))
    dut_a (.clk(clk), .rst_n(rst_n_v[0]), .vif(if_a));
  vga_timing_gen #(.H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                   .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .XBITS(5), .YBITS(4))
    dut_b (.clk(clk), .rst_n(rst_n_v[1]), .vif(if_b));
  vga_timing_gen dut_c (.clk(clk), .rst_n(rst_n_v[2]), .vif(if_c));
  vga_timing_gen #(.H_VISIBLE(MODE_800x600_60.h_visible), .H_FRONT(MODE_800x600_60.h_front),
                   .H_SYNC(MODE_800x600_60.h_sync), .H_BACK(MODE_800x600_60.h_back),
                   .V_VISIBLE(MODE_800x600_60.v_visible), .V_FRONT(MODE_800x600_60.v_front),
                   .V_SYNC(MODE_800x600_60.v_sync), .V_BACK(MODE_800x600_60.v_back),
                   .CLK_DIV(1), .HS_POL(MODE_800x600_60.hs_pol), .VS_POL(MODE_800x600_60.vs_pol),
                   .XBITS(11), .YBITS(10))
    dut_d (.clk(clk), .rst_n(rst_n_v[3]), .vif(if_d));

  assign got_v[0] = {16'(if_a.x), 16'(if_a.y), if_a.hsync, if_a.vsync, if_a.activevideo,
                     if_a.vblank, if_a.pix_tick, if_a.line_start, if_a.frame_start};
  assign got_v[1] = {16'(if_b.x), 16'(if_b.y), if_b.hsync, if_b.vsync, if_b.activevideo,
                     if_b.vblank, if_b.pix_tick, if_b.line_start, if_b.frame_start};
  assign got_v[2] = {16'(if_c.x), 16'(if_c.y), if_c.hsync, if_c.vsync, if_c.activevideo,
                     if_c.vblank, if_c.pix_tick, if_c.line_start, if_c.frame_start};
  assign got_v[3] = {16'(if_d.x), 16'(if_d.y), if_d.hsync, if_d.vsync, if_d.activevideo,
                     if_d.vblank, if_d.pix_tick, if_d.line_start, if_d.frame_start};

  // Reference model: raster position derived from the number of enabled
  // clocks since reset, t. pixel = t / DIV, x = pixel mod H_TOTAL,
  // y = (pixel / H_TOTAL) mod V_TOTAL.
  function automatic int h_tot(input int i);
    return T_HV[i] + T_HF[i] + T_HS[i] + T_HB[i];
  endfunction
  function automatic int v_tot(input int i);
    return T_VV[i] + T_VF[i] + T_VS[i] + T_VB[i];
  endfunction

  function automatic logic [38:0] model_out(input int i, input int t, input bit e,
                                            input bit ls, input bit fs);
    int pix = t / T_DIV[i];
    int x   = pix % h_tot(i);
    int y   = (pix / h_tot(i)) % v_tot(i);
    bit hs  = (x >= T_HV[i] + T_HF[i] && x < T_HV[i] + T_HF[i] + T_HS[i]) ? T_HP[i] : !T_HP[i];
    bit vs  = (y >= T_VV[i] + T_VF[i] && y < T_VV[i] + T_VF[i] + T_VS[i]) ? T_VP[i] : !T_VP[i];
    bit av  = (x < T_HV[i]) && (y < T_VV[i]);
    bit vb  = (y >= T_VV[i]);
    bit pt  = e && ((t % T_DIV[i]) == T_DIV[i] - 1);
    return {16'(x), 16'(y), hs, vs, av, vb, pt, ls, fs};
  endfunction

  // t_after = enabled clocks including the edge just taken
  function automatic bit line_edge(input int i, input int t_after);
    return ((t_after % T_DIV[i]) == 0) && (((t_after / T_DIV[i]) % h_tot(i)) == 0);
  endfunction
  function automatic bit frame_edge(input int i, input int t_after);
    return line_edge(i, t_after) && ((((t_after / T_DIV[i]) / h_tot(i)) % v_tot(i)) == 0);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_model
    int ticks = 0;
    bit ls_e  = 1'b0;
    bit fs_e  = 1'b0;
    always @(posedge clk or negedge rst_n_v[gi]) begin
      if (!rst_n_v[gi]) begin
        ticks <= 0;
        ls_e  <= 1'b0;
        fs_e  <= 1'b0;
      end else if (en_v[gi]) begin
        ticks <= ticks + 1;
        ls_e  <= line_edge(gi, ticks + 1);
        fs_e  <= frame_edge(gi, ticks + 1);
      end else begin
        ls_e  <= 1'b0;
        fs_e  <= 1'b0;
      end
    end
    always @(negedge clk) begin
      if (chk_on) check($sformatf("model%0d", gi), got_v[gi], model_out(gi, ticks, en_v[gi], ls_e, fs_e));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [38:0] RST_NEG = {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int n_ls, n_fs, n_pt0, fs_at, fs_prev, period, n_hs, first_x, max_x, max_y, n_vs, n_vb, n_av, n;
    bit found;
    #1 rst_n_v = 4'h0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_x", if_c.x, 0);
    check("rst_y", if_c.y, 0);
    check("rst_hsync", if_c.hsync, 1);
    check("rst_vsync", if_c.vsync, 1);
    check("rst_active", if_c.activevideo, 1);
    check("rst_vblank", if_c.vblank, 0);
    check("rst_strobes", {if_c.pix_tick, if_c.line_start, if_c.frame_start}, 0);
    check("rst_hsync_pos", {if_b.hsync, if_b.vsync}, 2'b00);
    @(posedge clk); #2 rst_n_v = 4'hF;

    // B: divide by one, two full frames from reset
    en_v[1] = 1'b1;
    n_ls = 0; n_fs = 0; n_pt0 = 0; fs_prev = -1; period = 0;
    for (int k = 0; k <= 460; k++) begin
      @(negedge clk);
      n_ls += int'(if_b.line_start);
      if (!if_b.pix_tick) n_pt0++;
      if (if_b.frame_start) begin
        n_fs++;
        if (fs_prev >= 0) period = k - fs_prev;
        fs_prev = k;
      end
    end
    check("b_line_starts", n_ls, 20);
    check("b_frame_starts", n_fs, 2);
    check("b_frame_period", period, 230);
    check("b_pix_tick_low", n_pt0, 0);

    // A: random enable stalls and occasional resets
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #2;
      en_v[0] = ($urandom_range(0, 9) != 0);
      rst_n_v[0] = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #2 rst_n_v[0] = 1'b1; en_v[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      found = (if_a.x == 20 && if_a.y == 10);
    end
    check("a_find_sync", found, 1);
    check("a_syncs_active", {if_a.hsync, if_a.vsync}, 2'b00);
    @(posedge clk); #2 rst_n_v[0] = 1'b0;
    #1 check("a_async_rst", got_v[0], RST_NEG);
    @(posedge clk); #2 rst_n_v[0] = 1'b1;
    first_x = -1; max_x = 0; max_y = 0; n_vs = 0; n_vb = 0; n_av = 0;
    for (int k = 0; k < 1260; k++) begin
      @(negedge clk);
      if (first_x < 0 && if_a.x != 0) first_x = k;
      if (int'(if_a.x) > max_x) max_x = int'(if_a.x);
      if (int'(if_a.y) > max_y) max_y = int'(if_a.y);
      n_vs += int'(!if_a.vsync);
      n_vb += int'(if_a.vblank);
      n_av += int'(if_a.activevideo);
    end
    check("a_first_x_step", first_x, 3);
    check("a_max_x", max_x, 27);
    check("a_max_y", max_y, 14);
    check("a_vsync_clks", n_vs, 168);
    check("a_vblank_clks", n_vb, 588);
    check("a_active_clks", n_av, 384);

    // C: default 640x480 at /4, one full line
    en_v[2] = 1'b1;
    n_hs = 0; first_x = -1; max_x = 0;
    for (int k = 0; k < 3200; k++) begin
      @(negedge clk);
      if (!if_c.hsync) begin
        n_hs++;
        if (first_x < 0) first_x = int'(if_c.x);
      end
      if (int'(if_c.x) > max_x) max_x = int'(if_c.x);
    end
    check("c_hsync_clks", n_hs, 96 * 4);
    check("c_hsync_first_x", first_x, 656);
    check("c_max_x", max_x, 799);

    // stall at x=639 with the prescaler at 2
    found = 1'b0;
    for (int k = 0; k < 3300 && !found; k++) begin
      found = (if_c.x == 639);
      if (!found) @(negedge clk);
    end
    check("c_find_639", found, 1);
    @(posedge clk); @(posedge clk); #2 en_v[2] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("c_stall", {if_c.pix_tick, 16'(if_c.x)}, {1'b0, 16'd639});
    end
    @(posedge clk); #2 en_v[2] = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); n++;
      #1 if (if_c.x != 639) break;
    end
    // held prescaler 2: one edge to reach 3, the next edge moves x
    check("c_resume_edges", n, 2);

    // asynchronous reset at x=700 (inside hsync)
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      found = (if_c.x == 700);
    end
    check("c_find_700", found, 1);
    check("c_hsync_before_rst", if_c.hsync, 0);
    @(posedge clk); #2 rst_n_v[2] = 1'b0;
    #1 check("c_async_rst", got_v[2], RST_NEG);
    @(posedge clk); #2 rst_n_v[2] = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); n++;
      #1 if (if_c.x != 0) break;
    end
    check("c_first_step_edges", n, 4);

    // D: 800x600 preset, one full line
    en_v[3] = 1'b1;
    n_hs = 0; first_x = -1; n_ls = 0;
    for (int k = 0; k < 1056; k++) begin
      @(negedge clk);
      if (if_d.hsync) begin
        n_hs++;
        if (first_x < 0) first_x = int'(if_d.x);
      end
      n_ls += int'(if_d.line_start);
    end
    @(negedge clk);
    check("d_hsync_clks", n_hs, 128);
    check("d_hsync_first_x", first_x, 840);
    check("d_no_early_ls", n_ls, 0);
    check("d_line_wrap", {if_d.line_start, 16'(if_d.x), 16'(if_d.y)}, {1'b1, 16'd0, 16'd1});

    en_v = 4'h0;
    repeat (4) @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
